fetch_mem_unit: RTL and testbench

- Holds the architectural PC, instruction register (IR), OldPC and data register for the multicycle RISC-V core.
- Muxes the unified memory address and runs a single-outstanding memory handshake with wait-state support.
- Sits between the control unit and memory. Consumes PCWrite/IRWrite/AddrSrc/MemWrite. Feeds `instr` back to the control unit and provides `stall` so the controller FSM freezes while memory is busy.

---
 rtl/fetch_mem_unit.sv | 212 +++++++++++++++++++++
 tb/tb_fetch_mem_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_mem_unit.sv
// fetch_mem_unit
// Holds the architectural PC, instruction register, OldPC and data register of
// the multicycle core. It also drives the unified memory port and runs a
// single-outstanding handshake that can be stretched by memory wait states.
//
// Build option: define FETCH_ALIGN_CHECK_EN to trap misaligned fetches. A
// trapped fetch loads a NOP and sets the sticky misalign_err port. When the
// option is off, fetch addresses are forced to word alignment.
//
// Ports
//   clk, reset         rising-edge clock; asynchronous active-high reset
//   PCWrite, Result    load the PC with Result (next PC or load/store address)
//   IRWrite            request an instruction fetch
//   DataRead           request a data load
//   MemWrite           request a data store
//   AddrSrc            selects the address: 0 = pc, 1 = Result
//   WriteData          store data
//   mem_*              memory request, address, write strobe/data, read data, ready
//   stall              controller must hold its state
//   instr, pc, old_pc  IR, PC, and the PC of the instruction in the IR
//   data               last loaded data word
//   bus_err            sticky wait-state timeout flag
//   misalign_err       sticky misaligned-fetch flag (FETCH_ALIGN_CHECK_EN only)
//
// state  | meaning
// S_IDLE | no access outstanding; a request completes here if memory is ready
// S_WAIT | access latched; waiting for mem_ready or the timeout
module fetch_mem_unit #(
   parameter int          XLEN           = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            PCWrite,
   input  logic            IRWrite,
   input  logic            DataRead,
   input  logic            MemWrite,
   input  logic            AddrSrc,
   input  logic [XLEN-1:0] Result,
   input  logic [XLEN-1:0] WriteData,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ready,
   output logic            stall,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] old_pc,
   output logic [XLEN-1:0] data,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic            misalign_err,
`endif
   output logic            bus_err
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;
   typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_t;

   state_t          state_q, state_d;
   kind_t           kind_in, lat_kind_q, done_kind;
   logic [7:0]      cnt_q;
   logic [XLEN-1:0] pc_q, pc_d, old_pc_q, old_pc_d, data_q, data_d;
   logic [31:0]     ir_q, ir_d;
   logic            bus_err_q;
   logic [XLEN-1:0] lat_addr_q, lat_wdata_q, lat_result_q;
   logic            lat_we_q, lat_pcw_q;

   logic            access, misalign, timeout, capture, done;
   logic [XLEN-1:0] adr, adr_out, rdata_eff;

   assign access  = IRWrite | DataRead | MemWrite;
   // Store beats load beats fetch if the controller ever raises more than one.
   assign kind_in = MemWrite ? K_STORE : (DataRead ? K_LOAD : K_FETCH);
   assign adr     = AddrSrc ? Result : pc_q;

`ifdef FETCH_ALIGN_CHECK_EN
   logic misalign_err_q;
   assign misalign = (state_q == S_IDLE) && access && (kind_in == K_FETCH)
                     && (adr[1:0] != 2'b00);
   assign adr_out  = adr;
   assign misalign_err = misalign_err_q;
`else
   assign misalign = 1'b0;
   assign adr_out  = (kind_in == K_FETCH) ? {adr[XLEN-1:2], 2'b00} : adr;
`endif

   // The last permitted wait cycle ends the access instead of stalling again.
   assign timeout = (state_q == S_WAIT) && !mem_ready
                    && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
   assign capture = (state_q == S_IDLE) && access && !misalign && !mem_ready;
   assign done    = (state_q == S_IDLE) ? (access && (mem_ready || misalign))
                                        : (mem_ready || timeout);
   assign done_kind = (state_q == S_IDLE) ? kind_in : lat_kind_q;
   assign rdata_eff = timeout ? '0 : mem_rdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (capture) state_d = S_WAIT;
         S_WAIT: if (mem_ready || timeout) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = adr_out;
      mem_wdata = WriteData;
      stall     = 1'b0;
      case (state_q)
         S_IDLE: begin
            mem_req = access && !misalign;
            mem_we  = MemWrite;
            stall   = access && !misalign && !mem_ready;
         end
         S_WAIT: begin
            mem_req   = 1'b1;
            mem_we    = lat_we_q;
            mem_addr  = lat_addr_q;
            mem_wdata = lat_wdata_q;
            stall     = !mem_ready && !timeout;
         end
         default: ;
      endcase
      // Reset abandons an access immediately, without waiting for the clock.
      if (reset) begin
         mem_req = 1'b0;
         mem_we  = 1'b0;
         stall   = 1'b0;
      end
   end

   always_comb begin
      pc_d     = pc_q;
      old_pc_d = old_pc_q;
      ir_d     = ir_q;
      data_d   = data_q;
      // A PCWrite raised with a stalled fetch is held and applied on completion.
      if (state_q == S_IDLE) begin
         if (PCWrite && !stall) pc_d = Result;
      end else if (done && lat_pcw_q) begin
         pc_d = lat_result_q;
      end
      if (done) begin
         case (done_kind)
            K_FETCH: begin
               ir_d     = misalign ? NOP_INSTR : rdata_eff[31:0];
               old_pc_d = pc_q;
            end
            K_LOAD:  data_d = rdata_eff;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         old_pc_q     <= RESET_PC;
         ir_q         <= NOP_INSTR;
         data_q       <= '0;
         bus_err_q    <= 1'b0;
         cnt_q        <= '0;
         lat_addr_q   <= '0;
         lat_wdata_q  <= '0;
         lat_result_q <= '0;
         lat_we_q     <= 1'b0;
         lat_pcw_q    <= 1'b0;
         lat_kind_q   <= K_FETCH;
      end else begin
         pc_q     <= pc_d;
         old_pc_q <= old_pc_d;
         ir_q     <= ir_d;
         data_q   <= data_d;
         if (timeout) bus_err_q <= 1'b1;
         if (state_q == S_IDLE) cnt_q <= '0;
         else                   cnt_q <= cnt_q + 8'd1;
         if (capture) begin
            lat_addr_q   <= adr_out;
            lat_wdata_q  <= WriteData;
            lat_result_q <= Result;
            lat_we_q     <= MemWrite;
            lat_pcw_q    <= PCWrite;
            lat_kind_q   <= kind_in;
         end
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         misalign_err_q <= 1'b0;
      else if (misalign) misalign_err_q <= 1'b1;
   end
`endif

   assign pc      = pc_q;
   assign old_pc  = old_pc_q;
   assign instr   = ir_q;
   assign data    = data_q;
   assign bus_err = bus_err_q;

endmodule

// File: tb/tb_fetch_mem_unit.sv
module tb_fetch_mem_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        PCWrite, IRWrite, DataRead, MemWrite, AddrSrc;
   logic [31:0] Result, WriteData, mem_rdata;
   logic        mem_ready;
   logic        mem_req, mem_we, stall, bus_err;
   logic [31:0] mem_addr, mem_wdata, instr, pc, old_pc, data;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        misalign_err;
`endif

   always #5 clk = ~clk;

   fetch_mem_unit dut (
      .clk(clk), .reset(reset),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .DataRead(DataRead),
      .MemWrite(MemWrite), .AddrSrc(AddrSrc),
      .Result(Result), .WriteData(WriteData),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall(stall), .instr(instr), .pc(pc), .old_pc(old_pc), .data(data),
`ifdef FETCH_ALIGN_CHECK_EN
      .misalign_err(misalign_err),
`endif
      .bus_err(bus_err)
   );

   typedef struct {
      string       tag;
      logic [31:0] instr;
      logic [31:0] opc;
      logic [31:0] data;
      logic [31:0] pc;
      logic        berr;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          nst;
   logic [31:0] m_instr, m_opc, m_data, m_pc;
   logic        m_berr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      PCWrite = 0; IRWrite = 0; DataRead = 0; MemWrite = 0; AddrSrc = 0;
      Result = '0; WriteData = '0; mem_rdata = '0; mem_ready = 1'b0;
   endtask

   task automatic model_reset();
      m_instr = 32'h0000_0013; m_opc = '0; m_data = '0; m_pc = '0; m_berr = 1'b0;
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      idle_in();
      tick();
      tick();
      reset = 1'b0;
      model_reset();
   endtask

   task automatic push_exp(input string tag);
      exp_t e;
      e.tag = tag; e.instr = m_instr; e.opc = m_opc; e.data = m_data;
      e.pc = m_pc; e.berr = m_berr;
      sb.push_back(e);
   endtask

   // Called just after the completion edge: the oldest expectation must match.
   task automatic retire();
      exp_t e;
      checks++;
      assert (sb.size() != 0)
      else begin
         errors++;
         $error("FAIL sb_underflow: observed 0 entries expected 1");
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({e.tag, "_instr"}, instr, e.instr);
         chk({e.tag, "_old_pc"}, old_pc, e.opc);
         chk({e.tag, "_data"}, data, e.data);
         chk({e.tag, "_pc"}, pc, e.pc);
         chk({e.tag, "_bus_err"}, {31'b0, bus_err}, {31'b0, e.berr});
      end
   endtask

   // Leaves the caller on a falling edge where stall is low, or reports a timeout.
   task automatic wait_done(output int nstall, input int limit);
      nstall = 0;
      @(negedge clk);
      while (stall === 1'b1 && nstall < limit) begin
         nstall++;
         tick();
         @(negedge clk);
      end
      checks++;
      assert (stall === 1'b0)
      else begin
         errors++;
         $error("FAIL wait_done_timeout: observed stall %b after %0d cycles expected 0", stall, nstall);
      end
   endtask

   initial begin
      // Reset state, with a request pending to show reset gates mem_req.
      reset = 1'b1;
      idle_in();
      model_reset();
      IRWrite = 1'b1;
      #12;
      chk("reset_pc", pc, 32'h0);
      chk("reset_old_pc", old_pc, 32'h0);
      chk("reset_instr", instr, 32'h0000_0013);
      chk("reset_data", data, 32'h0);
      chk("reset_bus_err", {31'b0, bus_err}, 32'h0);
      chk("reset_mem_req", {31'b0, mem_req}, 32'h0);
      chk("reset_stall", {31'b0, stall}, 32'h0);
      idle_in();
      tick();
      reset = 1'b0;

      // Zero-wait fetch with PC+4 on the same edge.
      IRWrite = 1; PCWrite = 1; Result = 32'h4; mem_ready = 1; mem_rdata = 32'h0050_0093;
      m_instr = 32'h0050_0093; m_opc = m_pc; m_pc = 32'h4;
      push_exp("fetch0");
      @(negedge clk);
      chk("fetch0_stall", {31'b0, stall}, 32'h0);
      chk("fetch0_req", {31'b0, mem_req}, 32'h1);
      chk("fetch0_addr", mem_addr, 32'h0);
      tick();
      idle_in();
      retire();

      // Fetch with three stalled cycles; inputs change while waiting and must be ignored.
      reset_dut();
      IRWrite = 1; PCWrite = 1; Result = 32'h4; mem_ready = 0;
      m_instr = 32'h00A0_0113; m_opc = m_pc; m_pc = 32'h4;
      push_exp("fetchw");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("fetchw_stall", {31'b0, stall}, 32'h1);
         chk("fetchw_addr", mem_addr, 32'h0);
         chk("fetchw_req", {31'b0, mem_req}, 32'h1);
         chk("fetchw_pc_hold", pc, 32'h0);
         tick();
         if (i == 0) begin
            IRWrite = 0; PCWrite = 0; AddrSrc = 1; Result = 32'h999;
         end
         if (i == 2) begin
            mem_ready = 1; mem_rdata = 32'h00A0_0113;
         end
      end
      @(negedge clk);
      chk("fetchw_release", {31'b0, stall}, 32'h0);
      chk("fetchw_addr_end", mem_addr, 32'h0);
      tick();
      idle_in();
      retire();

      // Load from Result with one wait state.
      AddrSrc = 1; Result = 32'h100; DataRead = 1; mem_ready = 0;
      m_data = 32'hDEAD_BEEF;
      push_exp("load");
      @(negedge clk);
      chk("load_addr", mem_addr, 32'h100);
      chk("load_stall", {31'b0, stall}, 32'h1);
      chk("load_we", {31'b0, mem_we}, 32'h0);
      tick();
      AddrSrc = 0; Result = 32'h555; DataRead = 0; mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("load_addr_held", mem_addr, 32'h100);
      chk("load_stall_end", {31'b0, stall}, 32'h0);
      tick();
      idle_in();
      retire();

      // Zero-wait store: no register changes.
      AddrSrc = 1; Result = 32'h200; MemWrite = 1; WriteData = 32'h1234_5678;
      mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
      push_exp("store");
      @(negedge clk);
      chk("store_req", {31'b0, mem_req}, 32'h1);
      chk("store_we", {31'b0, mem_we}, 32'h1);
      chk("store_wdata", mem_wdata, 32'h1234_5678);
      chk("store_addr", mem_addr, 32'h200);
      chk("store_stall", {31'b0, stall}, 32'h0);
      tick();
      idle_in();
      retire();
      @(negedge clk);
      chk("idle_no_req", {31'b0, mem_req}, 32'h0);
      tick();

      // Priority: load beats fetch, store beats load.
      AddrSrc = 1; Result = 32'h300; DataRead = 1; IRWrite = 1;
      mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
      m_data = 32'hCAFE_F00D;
      push_exp("prio_ld");
      @(negedge clk);
      chk("prio_ld_we", {31'b0, mem_we}, 32'h0);
      chk("prio_ld_addr", mem_addr, 32'h300);
      tick();
      idle_in();
      retire();
      AddrSrc = 1; Result = 32'h304; DataRead = 1; MemWrite = 1;
      mem_ready = 1; mem_rdata = 32'h1111_2222;
      push_exp("prio_st");
      @(negedge clk);
      chk("prio_st_we", {31'b0, mem_we}, 32'h1);
      tick();
      idle_in();
      retire();

`ifndef FETCH_ALIGN_CHECK_EN
      // Fetch address is word-aligned on the bus.
      AddrSrc = 1; Result = 32'h107; IRWrite = 1; mem_ready = 1; mem_rdata = 32'h0010_0013;
      m_instr = 32'h0010_0013; m_opc = m_pc;
      push_exp("fetch_al");
      @(negedge clk);
      chk("fetch_al_addr", mem_addr, 32'h104);
      tick();
      idle_in();
      retire();
`endif

      // PCWrite alone moves the PC without a memory request.
      PCWrite = 1; Result = 32'h40;
      @(negedge clk);
      chk("pcw_req", {31'b0, mem_req}, 32'h0);
      chk("pcw_stall", {31'b0, stall}, 32'h0);
      tick();
      idle_in();
      m_pc = 32'h40;
      chk("pcw_pc", pc, 32'h40);

      // Memory never ready: timeout after 255 stalled cycles, instr reads as zero.
      IRWrite = 1; PCWrite = 1; Result = 32'h44; mem_ready = 0; mem_rdata = 32'h7777_7777;
      m_instr = 32'h0; m_opc = m_pc; m_pc = 32'h44; m_berr = 1'b1;
      push_exp("tmo");
      wait_done(nst, 400);
      chk("tmo_stall_cycles", 32'(nst), 32'd255);
      chk("tmo_req_last", {31'b0, mem_req}, 32'h1);
      tick();
      idle_in();
      retire();

      // bus_err stays set across a later good fetch.
      IRWrite = 1; PCWrite = 1; Result = 32'h48; mem_ready = 1; mem_rdata = 32'h0020_0013;
      m_instr = 32'h0020_0013; m_opc = m_pc; m_pc = 32'h48;
      push_exp("sticky");
      tick();
      idle_in();
      retire();

      // Reset in the middle of a wait drops mem_req at once.
      IRWrite = 1; mem_ready = 0;
      @(negedge clk);
      chk("rstw_req_before", {31'b0, mem_req}, 32'h1);
      tick();
      tick();
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("rstw_req", {31'b0, mem_req}, 32'h0);
      chk("rstw_stall", {31'b0, stall}, 32'h0);
      chk("rstw_pc", pc, 32'h0);
      chk("rstw_bus_err", {31'b0, bus_err}, 32'h0);
      idle_in();
      tick();
      reset = 1'b0;
      model_reset();

      // Clean fetch after the abandoned access.
      IRWrite = 1; PCWrite = 1; Result = 32'h4; mem_ready = 1; mem_rdata = 32'h0030_0013;
      m_instr = 32'h0030_0013; m_opc = m_pc; m_pc = 32'h4;
      push_exp("post_rst");
      tick();
      idle_in();
      retire();

`ifdef FETCH_ALIGN_CHECK_EN
      // Misaligned fetch: no request, NOP loaded, sticky flag.
      reset_dut();
      PCWrite = 1; Result = 32'h2;
      tick();
      idle_in();
      m_pc = 32'h2;
      IRWrite = 1; mem_ready = 1; mem_rdata = 32'h0050_0093;
      m_instr = 32'h0000_0013; m_opc = 32'h2;
      push_exp("misal");
      @(negedge clk);
      chk("misal_req", {31'b0, mem_req}, 32'h0);
      chk("misal_stall", {31'b0, stall}, 32'h0);
      tick();
      idle_in();
      retire();
      chk("misal_flag", {31'b0, misalign_err}, 32'h1);
`endif

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
